data_word_arbiter: RTL and testbench
====================================

# data_word_arbiter

Two-requester round-robin arbiter and sequencer for the shared 16-bit `data` word sampled by the reset/data property checker. It grants one requester at a time with a valid/ready handshake and loads the winner's word into the shared register. It holds that word stable with `data_valid` for a fixed number of cycles, then returns to idle. It guarantees `data` is zero the cycle after reset is sampled, which is the invariant the checker relies on.

## Interface
Parameters:
- `WIDTH`, 16, width of the shared data word.
- `HOLD_CYCLES`, 2, cycles a loaded word is presented with `data_valid` high; legal range 1..255.

Ports:
- `clk`  in  1  single clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `req0_valid`  in  1  requester 0 has a word.
- `req0_data`  in  WIDTH  requester 0 word.
- `req0_ready`  out  1  requester 0 granted; transfer on `valid && ready`.
- `req1_valid`, `req1_data`, `req1_ready`  same as above, requester 1.
- `data`  out  WIDTH  shared data register.
- `data_valid`  out  1  `data` holds a freshly loaded word.
- `owner`  out  1  index of the requester that last loaded `data`.
- `busy`  out  1  FSM not in IDLE.

## Operation
- FSM states: IDLE and HOLD. 8-bit hold counter `hold_cnt`. Priority pointer `prio`.
- `prio`: 0 means requester 0 wins a tie.
- IDLE:
  - Winner is the only valid requester. If both are valid, the winner is `prio`.
  - The winner's ready is asserted combinationally in the same cycle.
  - The loser's ready is low.
  - Neither ready is asserted if no requester is valid.
- Handshake at an IDLE edge:
  - `data` <= winner data; `owner` <= winner; `data_valid` <= 1.
  - `hold_cnt` <= HOLD_CYCLES-1; `prio` <= ~winner; state <= HOLD.
- HOLD:
  - Both readies low; `data_valid` high; `busy` high.
  - If `hold_cnt`==0, state <= IDLE and `data_valid` <= 0. Otherwise `hold_cnt` decrements.
- `data` and `owner` retain their last value in IDLE; they are not cleared.
- `prio` updates only on a handshake. A single active requester is never blocked by the pointer.
- Requester rule: once `valid` is raised, `valid` and `data` stay stable until ready.
- At most one ready is ever high.

## Timing
- Reset values, one edge after `reset` is sampled high:
  - `data`=0, `data_valid`=0, `owner`=0, `busy`=0.
  - state=IDLE, `prio`=0, `hold_cnt`=0.
- Both readies are forced low combinationally while `reset` is high.
- Latency: ready is asserted in the same cycle as valid when IDLE. `data` and `data_valid` update one edge after the handshake.
- For a handshake at edge T:
  - `data_valid` is high for cycles T+1..T+HOLD_CYCLES and low from T+HOLD_CYCLES+1.
  - The next handshake is possible at edge T+HOLD_CYCLES+1.
  - Peak throughput is one word per HOLD_CYCLES+1 cycles.
- Reset during HOLD aborts the hold. The next edge gives reset values, and the in-flight word is lost.
- Reset and a handshake in the same cycle: reset wins. No transfer occurs, because readies are low.
- Valid arriving during HOLD waits; it is evaluated in the first IDLE cycle.
- `hold_cnt` never wraps. It is reloaded on every handshake.

## Configuration
- `DATA_ARB_ASSERT_EN` defined: in-module SVA checks are compiled, all disabled iff `reset`:
  - `$rose(reset) |=> data == 0`
  - `!(req0_ready && req1_ready)`
  - `data_valid |-> busy`
  - `reqN_valid && !reqN_ready |=> reqN_valid && $stable(reqN_data)`
  - Each check raises `$error` on failure.
- `DATA_ARB_ASSERT_EN` undefined: no assertion code is compiled, and RTL behaviour is identical.

## Test plan
- Reset: hold `reset` 3 cycles with both requesters valid. Required: readies 0 throughout; `data`=16'h0000, `data_valid`=0, `owner`=0, `busy`=0 after the first edge.
- Single transfer, HOLD_CYCLES=2: `req0_valid` with 16'hA5A5 in IDLE. Required: `req0_ready` high the same cycle; `data`=16'hA5A5, `owner`=0, `data_valid`=1 for exactly 2 cycles; ready again on the 3rd cycle after the handshake.
- Contention: both valid continuously; req0 with 16'h1111, req1 with 16'h2222. Required: grants alternate 0,1,0,1 starting with req0; `data` alternates 1111/2222; one grant every 3 cycles.
- Lone requester: only `req1_valid`, 4 back-to-back words. Required: all 4 granted at 3-cycle spacing with no stall from `prio`.
- Reset mid-HOLD: assert `reset` the cycle after loading 16'hBEEF. Required: next edge `data`=0, `data_valid`=0, `busy`=0; `prio` back to 0.
- Macro on: drop `req1_valid` while it is not granted (req0 in HOLD). Required: the stability assertion fires. With the macro off, the same stimulus compiles and runs with no assertion messages.

Source files
------------

// File: rtl/data_word_arbiter.sv
// rtl/data_word_arbiter.sv - two-requester round-robin arbiter loading a shared data word
// Optional in-module checks compiled when DATA_ARB_ASSERT_EN is defined.
module data_word_arbiter #(
    parameter int WIDTH       = 16,
    parameter int HOLD_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic [WIDTH-1:0] data,
    output logic             data_valid,
    output logic             owner,
    output logic             busy
);

    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           state, state_next;
    logic [7:0]       hold_cnt, hold_cnt_next;
    logic             prio, prio_next;
    logic [WIDTH-1:0] data_q, data_next;
    logic             owner_q, owner_next;
    logic             data_valid_q, data_valid_next;
    logic             grant0, grant1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            hold_cnt     <= 8'd0;
            prio         <= 1'b0;
            data_q       <= '0;
            owner_q      <= 1'b0;
            data_valid_q <= 1'b0;
        end else begin
            state        <= state_next;
            hold_cnt     <= hold_cnt_next;
            prio         <= prio_next;
            data_q       <= data_next;
            owner_q      <= owner_next;
            data_valid_q <= data_valid_next;
        end
    end

    always_comb begin
        state_next      = state;
        hold_cnt_next   = hold_cnt;
        prio_next       = prio;
        data_next       = data_q;
        owner_next      = owner_q;
        data_valid_next = data_valid_q;
        grant0          = 1'b0;
        grant1          = 1'b0;
        case (state)
            IDLE: begin
                // Readies are gated by reset so a reset cycle can never transfer.
                if (!reset) begin
                    if (req0_valid && (!req1_valid || !prio)) begin
                        grant0 = 1'b1;
                    end else if (req1_valid) begin
                        grant1 = 1'b1;
                    end
                end
                if (grant0 || grant1) begin
                    data_next       = grant1 ? req1_data : req0_data;
                    owner_next      = grant1;
                    data_valid_next = 1'b1;
                    hold_cnt_next   = HOLD_LOAD;
                    prio_next       = ~grant1;
                    state_next      = HOLD;
                end
            end
            HOLD: begin
                if (hold_cnt == 8'd0) begin
                    state_next      = IDLE;
                    data_valid_next = 1'b0;
                end else begin
                    hold_cnt_next = hold_cnt - 8'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign data       = data_q;
    assign data_valid = data_valid_q;
    assign owner      = owner_q;
    assign busy       = (state == HOLD);

`ifdef DATA_ARB_ASSERT_EN
    a_reset_zero: assert property (@(posedge clk) disable iff (reset)
        $rose(reset) |=> data == '0)
        else $error("data not zero after reset");

    a_one_ready: assert property (@(posedge clk) disable iff (reset)
        !(req0_ready && req1_ready))
        else $error("both readies high");

    a_valid_busy: assert property (@(posedge clk) disable iff (reset)
        data_valid |-> busy)
        else $error("data_valid without busy");

    a_req0_stable: assert property (@(posedge clk) disable iff (reset)
        req0_valid && !req0_ready |=> req0_valid && $stable(req0_data))
        else $error("requester 0 changed before ready");

    a_req1_stable: assert property (@(posedge clk) disable iff (reset)
        req1_valid && !req1_ready |=> req1_valid && $stable(req1_data))
        else $error("requester 1 changed before ready");
`else
`endif

endmodule

// File: tb/tb_data_word_arbiter.sv
// tb/tb_data_word_arbiter.sv - self-checking bench for data_word_arbiter against a cycle model
module tb_data_word_arbiter;

    localparam int H = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic [15:0] req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic [15:0] data;
    logic        data_valid, owner, busy;

    int total = 0;
    int bad   = 0;

    data_word_arbiter #(.WIDTH(16), .HOLD_CYCLES(H)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .data(data), .data_valid(data_valid), .owner(owner), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: words-left-to-present counter instead of an FSM.
    logic [15:0] m_data  = '0;
    logic        m_owner = 1'b0;
    logic        m_prio  = 1'b0;
    int          m_left  = 0;
    bit          armed   = 0;
    bit          hs0_seen, hs1_seen;

    function automatic logic exp_ready(input int idx);
        logic mine, other;
        mine  = (idx == 0) ? req0_valid : req1_valid;
        other = (idx == 0) ? req1_valid : req0_valid;
        return !reset && (m_left == 0) && mine && (!other || (m_prio == idx[0]));
    endfunction

    always @(posedge clk) begin
        logic e0, e1;
        e0 = exp_ready(0);
        e1 = exp_ready(1);
        hs0_seen = req0_valid && req0_ready;
        hs1_seen = req1_valid && req1_ready;
        if (reset) begin
            m_data = '0; m_owner = 1'b0; m_prio = 1'b0; m_left = 0;
        end else if (e0 || e1) begin
            m_data  = e1 ? req1_data : req0_data;
            m_owner = e1;
            m_prio  = !e1;
            m_left  = H;
        end else if (m_left > 0) begin
            m_left--;
        end
        armed = 1;
    end

    always @(negedge clk) begin
        if (armed) begin
            check("ready0", req0_ready, exp_ready(0));
            check("ready1", req1_ready, exp_ready(1));
            check("data", data, m_data);
            check("data_valid", data_valid, m_left > 0);
            check("owner", owner, m_owner);
            check("busy", busy, m_left > 0);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    int n, ng;
    int gc[4];
    int go[4];
    logic [15:0] words[4];

    initial begin
        reset = 1'b1;
        req0_valid = 1'b1; req0_data = 16'h1234;
        req1_valid = 1'b1; req1_data = 16'h5678;
        tick;
        check("rst_data", data, 16'h0000);
        check("rst_dv", data_valid, 0);
        check("rst_owner", owner, 0);
        check("rst_busy", busy, 0);
        check("rst_rdy0", req0_ready, 0);
        check("rst_rdy1", req1_ready, 0);
        tick; tick;
        check("rst_rdy_hold", {req0_ready, req1_ready}, 0);

        // single transfer
        reset = 1'b0; req1_valid = 1'b0; req0_data = 16'hA5A5;
        #1;
        check("single_rdy_same_cycle", req0_ready, 1);
        tick;
        req0_data = 16'h0001;
        #1;
        check("single_data", data, 16'hA5A5);
        check("single_owner", owner, 0);
        check("single_dv1", data_valid, 1);
        check("single_rdy_low", req0_ready, 0);
        n = 0;
        while (!req0_ready && n < 10) begin
            tick; n++;
            if (n == 1) check("single_dv2", data_valid, 1);
            if (n == 2) check("single_dv_off", data_valid, 0);
        end
        check("single_regrant_gap", n, 2);
        tick;
        req0_valid = 1'b0;

        // contention
        reset = 1'b1; tick; reset = 1'b0;
        req0_valid = 1'b1; req0_data = 16'h1111;
        req1_valid = 1'b1; req1_data = 16'h2222;
        ng = 0;
        for (int c = 0; c < 20 && ng < 4; c++) begin
            #1;
            if (req0_ready) begin go[ng] = 0; gc[ng] = c; ng++; end
            else if (req1_ready) begin go[ng] = 1; gc[ng] = c; ng++; end
            tick;
            if (ng > 0 && gc[ng-1] == c)
                check("cont_data", data, go[ng-1] ? 16'h2222 : 16'h1111);
        end
        check("cont_grants", ng, 4);
        for (int i = 0; i < 4; i++) check("cont_owner", go[i], i % 2);
        for (int i = 0; i < 3; i++) check("cont_spacing", gc[i+1] - gc[i], 3);
        req0_valid = 1'b0; req1_valid = 1'b0;

        // lone requester 1
        words[0] = 16'hC001; words[1] = 16'hC002; words[2] = 16'hC003; words[3] = 16'hC004;
        reset = 1'b1; tick; reset = 1'b0;
        req1_valid = 1'b1; req1_data = words[0];
        ng = 0;
        for (int c = 0; c < 30 && ng < 4; c++) begin
            #1;
            if (req1_ready) begin gc[ng] = c; ng++; end
            tick;
            if (ng > 0 && gc[ng-1] == c) begin
                check("lone_data", data, words[ng-1]);
                if (ng < 4) req1_data = words[ng];
                else req1_valid = 1'b0;
            end
        end
        check("lone_grants", ng, 4);
        check("lone_first_immediate", gc[0], 0);
        for (int i = 0; i < 3; i++) check("lone_spacing", gc[i+1] - gc[i], 3);
        req1_valid = 1'b0;

        // reset mid-hold
        reset = 1'b1; tick; reset = 1'b0;
        req0_valid = 1'b1; req0_data = 16'hBEEF;
        tick;
        req0_valid = 1'b0;
        check("mid_loaded", data, 16'hBEEF);
        reset = 1'b1;
        tick;
        check("mid_data", data, 16'h0000);
        check("mid_dv", data_valid, 0);
        check("mid_busy", busy, 0);
        reset = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        check("mid_prio_rdy0", req0_ready, 1);
        check("mid_prio_rdy1", req1_ready, 0);
        tick;
        req0_valid = 1'b0;

        // requester 1 withdraws while req0 is held
        tick;
        req1_valid = 1'b0;
        tick; tick; tick;

        // randomized traffic with occasional reset
        for (int c = 0; c < 2000; c++) begin
            if (req0_valid && hs0_seen && $urandom_range(0, 1) == 0) req0_valid = 1'b0;
            else if (req0_valid && hs0_seen) req0_data = 16'($urandom);
            if (!req0_valid && $urandom_range(0, 2) == 0) begin
                req0_valid = 1'b1; req0_data = 16'($urandom);
            end
            if (req1_valid && hs1_seen && $urandom_range(0, 1) == 0) req1_valid = 1'b0;
            else if (req1_valid && hs1_seen) req1_data = 16'($urandom);
            if (!req1_valid && $urandom_range(0, 2) == 0) begin
                req1_valid = 1'b1; req1_data = 16'($urandom);
            end
            reset = ($urandom_range(0, 96) == 0);
            tick;
        end
        reset = 1'b0;
        tick;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
